ysyx_040750_trap_seq: RTL
=========================

Name: ysyx_040750_trap_seq

Overview:
- Trap/return sequencer for the machine-mode CSR file; sits beside the CSR forwarding network at the WB boundary.
- Accepts ecall/ebreak/illegal/mret requests from WB, stalls the pipeline and waits for in-flight CSR writes to drain.
- Performs the required CSR updates one per cycle through the single CSR write port, then issues a PC redirect and a flush to IF.

Parameters:
- XLEN, 64, data/PC width
- DRAIN_MAX, 15, max cycles in DRAIN before sticky error; 4-bit counter

Ports:
- I_sys_clk  in  1  clock
- I_rst  in  1  synchronous active-high reset
- I_trap_valid  in  1  trap/return request from WB
- O_trap_ready  out  1  request accepted this cycle (= state IDLE)
- I_trap_kind  in  2  00 ecall, 01 ebreak, 10 illegal, 11 mret
- I_trap_pc  in  XLEN  PC of trapping instruction
- I_csr_pending  in  1  any CSR write valid in EX/MEM/WB
- I_csr_mstatus  in  XLEN  current mstatus from CSR file
- I_csr_mtvec  in  XLEN  current mtvec
- I_csr_mepc  in  XLEN  current mepc
- O_csr_wen  out  1  sequencer CSR write enable (owns port when high)
- O_csr_waddr  out  12  CSR address
- O_csr_wdata  out  XLEN  CSR write data
- O_stall  out  1  freeze pipeline
- O_redirect_valid  out  1  redirect PC valid
- O_redirect_pc  out  XLEN  target PC
- I_redirect_ready  in  1  IF accepts redirect
- O_flush  out  1  one-cycle flush pulse
- O_drain_err  out  1  sticky drain timeout

Behaviour:
- States: IDLE, DRAIN, WR_MEPC, WR_MCAUSE, WR_MSTATUS, REDIRECT.
- Reset: state IDLE; all outputs 0 except O_trap_ready=1; captured pc/kind and counter cleared; O_drain_err cleared. Reset mid-sequence aborts immediately with no further CSR writes.
- IDLE: O_trap_ready=1. On I_trap_valid, capture pc/kind and go to DRAIN.
- O_stall=1 in every state except IDLE.
- DRAIN: remain while I_csr_pending=1; the counter increments each cycle and saturates at DRAIN_MAX. Reaching DRAIN_MAX sets O_drain_err (sticky until reset); the FSM keeps waiting. When pending=0: ecall/ebreak/illegal go to WR_MEPC; mret goes to WR_MSTATUS.
- WR_MEPC: wen=1, addr 0x341, data=captured pc with bit0 cleared.
- WR_MCAUSE: wen=1, addr 0x342, data=11/3/2 for ecall/ebreak/illegal.
- WR_MSTATUS, trap entry: MPIE(7)=MIE(3), MIE=0, MPP(12:11)=11, other bits unchanged.
- WR_MSTATUS, mret: MIE=MPIE, MPIE=1, MPP=11.
- mstatus is sampled from I_csr_mstatus in the WR_MSTATUS cycle.
- REDIRECT: O_redirect_valid=1. O_redirect_pc is {mtvec[XLEN-1:2],2'b00} for trap entry, or I_csr_mepc for mret. Target is sampled on REDIRECT entry and held stable. Hold until I_redirect_ready. The handshake cycle asserts O_flush=1; next state IDLE.
- O_csr_wen is high only in WR_* states. Exactly 3 writes per trap entry, 1 per mret.
- Latency with no pending writes:
  - trap entry: accept at T, writes at T+2..T+4, redirect at T+5.
  - mret: write at T+2, redirect at T+3.
- I_trap_valid outside IDLE is ignored (ready=0).

Optional Feature:
- Macro TRAP_SEQ_TIMER_IRQ_EN. When defined, adds ports:
  - I_mtip (1)
  - I_mie_mtie (1)
  - I_irq_pc_valid (1)
  - I_irq_pc (XLEN)
- In IDLE, with I_trap_valid=0, I_mtip & I_mie_mtie & mstatus.MIE & I_irq_pc_valid: accept the interrupt and run the trap-entry sequence with mepc=I_irq_pc and mcause=0x8000_0000_0000_0007.
- Synchronous requests win over the interrupt in the same cycle.
- When not defined: no extra ports; interrupts are never taken.

Decomposition:
- Shared package:
  - CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342)
  - cause codes
  - trap-kind encoding
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11)
  - FSM state enum
- Optional sub-module: ysyx_040750_mstatus_next, a combinational entry/return mstatus update. It is reusable by the CSR file for a future single-cycle path.

Test Plan:
- ecall, pc=0x8000_0010, pending=0, mtvec=0x8000_0103, mstatus=0x8 → writes (0x341,0x8000_0010), (0x342,11), (0x300,0x1880), then redirect_pc=0x8000_0100; flush on ready.
- mret, mstatus=0x1880, mepc=0x8000_0014 → single write (0x300,0x1888), redirect to 0x8000_0014; stall low the cycle after flush.
- ebreak with pending high for 3 cycles → no CSR write until pending drops; mcause=3; redirect delayed exactly 3 cycles.
- pending held 20 cycles → O_drain_err sets at counter 15 and stays; sequence completes after pending drops; reset clears err.
- Reset asserted during WR_MCAUSE → next cycle IDLE, wen=0, stall=0, no redirect. Request during REDIRECT with ready=0 → ignored, redirect held stable.
- (macro on) mtip=mtie=MIE=1, irq_pc=0x8000_0020, trap_valid=0 → mcause 0x8000_0000_0000_0007, mepc 0x8000_0020. Same cycle with ecall → ecall taken.

Source files
------------

// File: rtl/ysyx_040750_trap_seq_pkg.sv
// rtl/ysyx_040750_trap_seq_pkg.sv - shared CSR addresses, cause codes, trap kinds and FSM states
package ysyx_040750_trap_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int CAUSE_ILLEGAL     = 2;
  localparam int CAUSE_BREAKPOINT  = 3;
  localparam int CAUSE_ECALL_M     = 11;
  localparam int CAUSE_M_TIMER_IRQ = 7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {
    KIND_ECALL   = 2'b00,
    KIND_EBREAK  = 2'b01,
    KIND_ILLEGAL = 2'b10,
    KIND_MRET    = 2'b11
  } trap_kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_WR_MEPC,
    S_WR_MCAUSE,
    S_WR_MSTATUS,
    S_REDIRECT
  } state_e;

endpackage

// File: rtl/ysyx_040750_mstatus_next.sv
// rtl/ysyx_040750_mstatus_next.sv - combinational mstatus update for trap entry or mret
module ysyx_040750_mstatus_next
  import ysyx_040750_trap_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_mstatus,
  input  logic            i_is_mret,
  output logic [XLEN-1:0] o_mstatus
);

  always_comb begin
    o_mstatus = i_mstatus;
    o_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    if (i_is_mret) begin
      o_mstatus[MSTATUS_MIE]  = i_mstatus[MSTATUS_MPIE];
      o_mstatus[MSTATUS_MPIE] = 1'b1;
    end else begin
      o_mstatus[MSTATUS_MPIE] = i_mstatus[MSTATUS_MIE];
      o_mstatus[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_040750_trap_seq.sv
// rtl/ysyx_040750_trap_seq.sv - trap/mret sequencer driving the CSR write port, then redirect+flush
// Optional machine-timer interrupt entry enabled by TRAP_SEQ_TIMER_IRQ_EN.
module ysyx_040750_trap_seq
  import ysyx_040750_trap_seq_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 15
) (
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_trap_valid,
  output logic            O_trap_ready,
  input  logic [1:0]      I_trap_kind,
  input  logic [XLEN-1:0] I_trap_pc,
  input  logic            I_csr_pending,
  input  logic [XLEN-1:0] I_csr_mstatus,
  input  logic [XLEN-1:0] I_csr_mtvec,
  input  logic [XLEN-1:0] I_csr_mepc,
  output logic            O_csr_wen,
  output logic [11:0]     O_csr_waddr,
  output logic [XLEN-1:0] O_csr_wdata,
  output logic            O_stall,
  output logic            O_redirect_valid,
  output logic [XLEN-1:0] O_redirect_pc,
  input  logic            I_redirect_ready,
  output logic            O_flush,
`ifdef TRAP_SEQ_TIMER_IRQ_EN
  input  logic            I_mtip,
  input  logic            I_mie_mtie,
  input  logic            I_irq_pc_valid,
  input  logic [XLEN-1:0] I_irq_pc,
`endif
  output logic            O_drain_err
);

  state_e          r_state, w_state_nxt;
  trap_kind_e      r_kind;
  logic            r_irq;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_redirect_pc;
  logic [3:0]      r_cnt;
  logic            r_drain_err;

  logic            w_take_irq;
  logic [XLEN-1:0] w_cap_pc;
  logic            w_is_mret;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_mstatus_nxt;
  logic [XLEN-1:0] w_mtvec_base;

`ifdef TRAP_SEQ_TIMER_IRQ_EN
  // Synchronous requests from WB take priority over the timer interrupt.
  assign w_take_irq = !I_trap_valid && I_mtip && I_mie_mtie
                      && I_csr_mstatus[MSTATUS_MIE] && I_irq_pc_valid;
  assign w_cap_pc   = I_trap_valid ? I_trap_pc : I_irq_pc;
`else
  assign w_take_irq = 1'b0;
  assign w_cap_pc   = I_trap_pc;
`endif

  assign w_is_mret    = (r_kind == KIND_MRET) && !r_irq;
  assign w_mtvec_base = I_csr_mtvec & ~XLEN'(3);

  always_comb begin
    if (r_irq) begin
      w_cause = {1'b1, (XLEN-1)'(CAUSE_M_TIMER_IRQ)};
    end else begin
      case (r_kind)
        KIND_EBREAK:  w_cause = XLEN'(CAUSE_BREAKPOINT);
        KIND_ILLEGAL: w_cause = XLEN'(CAUSE_ILLEGAL);
        default:      w_cause = XLEN'(CAUSE_ECALL_M);
      endcase
    end
  end

  ysyx_040750_mstatus_next #(.XLEN(XLEN)) u_mstatus_next (
    .i_mstatus (I_csr_mstatus),
    .i_is_mret (w_is_mret),
    .o_mstatus (w_mstatus_nxt)
  );

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    O_trap_ready     = 1'b0;
    O_stall          = 1'b1;
    O_csr_wen        = 1'b0;
    O_csr_waddr      = 12'h000;
    O_csr_wdata      = '0;
    O_redirect_valid = 1'b0;
    O_flush          = 1'b0;
    case (r_state)
      S_IDLE: begin
        O_trap_ready = 1'b1;
        O_stall      = 1'b0;
        if (I_trap_valid || w_take_irq) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!I_csr_pending) w_state_nxt = w_is_mret ? S_WR_MSTATUS : S_WR_MEPC;
      end
      S_WR_MEPC: begin
        O_csr_wen   = 1'b1;
        O_csr_waddr = CSR_MEPC;
        O_csr_wdata = r_pc & ~XLEN'(1);
        w_state_nxt = S_WR_MCAUSE;
      end
      S_WR_MCAUSE: begin
        O_csr_wen   = 1'b1;
        O_csr_waddr = CSR_MCAUSE;
        O_csr_wdata = w_cause;
        w_state_nxt = S_WR_MSTATUS;
      end
      S_WR_MSTATUS: begin
        O_csr_wen   = 1'b1;
        O_csr_waddr = CSR_MSTATUS;
        O_csr_wdata = w_mstatus_nxt;
        w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        O_redirect_valid = 1'b1;
        if (I_redirect_ready) begin
          O_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_kind        <= KIND_ECALL;
      r_irq         <= 1'b0;
      r_pc          <= '0;
      r_redirect_pc <= '0;
      r_cnt         <= 4'd0;
      r_drain_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && (I_trap_valid || w_take_irq)) begin
        r_pc  <= w_cap_pc;
        r_irq <= !I_trap_valid;
        r_kind <= I_trap_valid ? trap_kind_e'(I_trap_kind) : KIND_ECALL;
        r_cnt <= 4'd0;
      end
      // Error flags the cycle the saturating counter reaches DRAIN_MAX; FSM keeps waiting.
      if (r_state == S_DRAIN && I_csr_pending) begin
        if (r_cnt != 4'(DRAIN_MAX)) r_cnt <= r_cnt + 4'd1;
        if (r_cnt >= 4'(DRAIN_MAX - 1)) r_drain_err <= 1'b1;
      end
      if (r_state == S_WR_MSTATUS)
        r_redirect_pc <= w_is_mret ? I_csr_mepc : w_mtvec_base;
    end
  end

  assign O_redirect_pc = r_redirect_pc;
  assign O_drain_err   = r_drain_err;

endmodule
